mem_access_unit: RTL

- Memory-side stage sitting directly upstream of the multicycle control unit; owns all instruction and data memory traffic.
- Turns the level-held mem_read / mem_write / i_or_d strobes into single handshaked transactions on a variable-latency memory port.
- Captures the fetched word (fetch buffer, IR) and the loaded word (MDR); supplies opcode/func_code to control.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_perf_counters.sv | 41 ++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: FSM states, access kinds and
// instruction field positions also used by the control unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  // Access kind is {i_or_d, we}; any kind with the we bit set is a store.
  typedef logic [1:0] ma_kind_t;

  localparam ma_kind_t KIND_FETCH = 2'b00;
  localparam ma_kind_t KIND_LOAD  = 2'b10;
  localparam ma_kind_t KIND_STORE = 2'b11;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  function automatic ma_kind_t make_kind(input logic i_or_d, input logic we);
    return {i_or_d, we};
  endfunction

  function automatic logic kind_is_store(input ma_kind_t kind);
    return kind[0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Variable-latency memory port: the access unit drives the request side, the
// memory answers with a one-cycle ack carrying read data.
interface mem_access_unit_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 16
) ();

  logic [ADDR_W-1:0] ext_addr;
  logic              ext_req;
  logic              ext_we;
  logic [WORD_W-1:0] ext_wdata;
  logic [WORD_W-1:0] ext_rdata;
  logic              ext_ack;

  modport master (
    output ext_addr,
    output ext_req,
    output ext_we,
    output ext_wdata,
    input  ext_rdata,
    input  ext_ack
  );

  modport slave (
    input  ext_addr,
    input  ext_req,
    input  ext_we,
    input  ext_wdata,
    output ext_rdata,
    output ext_ack
  );

endinterface

// File: rtl/mem_perf_counters.sv
// Saturating per-kind transaction counters; only instantiated when
// MEM_PERF_CNT_EN is defined.
module mem_perf_counters
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        done,
  input  ma_kind_t    kind,
  output logic [31:0] fetch_cnt,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  logic [31:0] fetch_q, load_q, store_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_q <= '0;
      load_q  <= '0;
      store_q <= '0;
    end else if (done) begin
      if (kind_is_store(kind)) begin
        store_q <= sat_inc(store_q);
      end else if (kind == KIND_FETCH) begin
        fetch_q <= sat_inc(fetch_q);
      end else begin
        load_q <= sat_inc(load_q);
      end
    end
  end

  assign fetch_cnt = fetch_q;
  assign load_cnt  = load_q;
  assign store_cnt = store_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: turns level-held control strobes into single handshaked
// memory transactions and holds fetch buffer, IR and MDR. MEM_PERF_CNT_EN adds counters.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [WORD_W-1:0] wdata_in,
  mem_access_unit_if.master mem,
  output logic [WORD_W-1:0] fetch_buf,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] mdr,
  output logic [3:0]        opcode,
  output logic [5:0]        func_code,
`ifdef MEM_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
`endif
  output logic              mem_done,
  output logic              mem_busy
);

  ma_state_e         state_q, state_d;
  logic [2:0]        key, last_key_q, last_key_d;
  logic              accept;
  logic              req_q, req_d;
  ma_kind_t          kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] fetch_buf_q, fetch_buf_d, ir_q, ir_d, mdr_q, mdr_d;

  // A held strobe keeps the same key, so it is issued only once.
  assign key    = {mem_read, mem_write, i_or_d};
  assign accept = (mem_read | mem_write) && (key != last_key_q);

  always_comb begin
    state_d     = state_q;
    last_key_d  = last_key_q;
    req_d       = req_q;
    kind_d      = kind_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fetch_buf_d = fetch_buf_q;
    mdr_d       = mdr_q;
    ir_d        = ir_write ? fetch_buf_q : ir_q;

    case (state_q)
      MA_IDLE: begin
        last_key_d = key;
        if (accept) begin
          state_d = MA_REQ;
          req_d   = 1'b1;
          addr_d  = i_or_d ? alu_out : pc;
          wdata_d = wdata_in;
          // Read and write together resolves to a write.
          kind_d  = make_kind(i_or_d, mem_write);
        end
      end
      MA_REQ: begin
        if (mem.ext_ack) begin
          state_d = MA_DONE;
          req_d   = 1'b0;
          if (!kind_is_store(kind_q)) begin
            if (kind_q == KIND_FETCH) fetch_buf_d = mem.ext_rdata;
            else                      mdr_d       = mem.ext_rdata;
          end
        end
      end
      MA_DONE: begin
        last_key_d = key;
        state_d    = MA_IDLE;
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MA_IDLE;
      last_key_q  <= '0;
      req_q       <= 1'b0;
      kind_q      <= KIND_FETCH;
      addr_q      <= '0;
      wdata_q     <= '0;
      fetch_buf_q <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_key_q  <= last_key_d;
      req_q       <= req_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fetch_buf_q <= fetch_buf_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
    end
  end

  assign mem.ext_addr  = addr_q;
  assign mem.ext_req   = req_q;
  assign mem.ext_we    = kind_is_store(kind_q);
  assign mem.ext_wdata = wdata_q;

  assign fetch_buf = fetch_buf_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign opcode    = fetch_buf_q[OPCODE_MSB:OPCODE_LSB];
  assign func_code = fetch_buf_q[FUNC_MSB:FUNC_LSB];
  assign mem_done  = (state_q == MA_DONE);
  assign mem_busy  = (state_q == MA_REQ);

`ifdef MEM_PERF_CNT_EN
  mem_perf_counters u_perf (
    .clk       (clk),
    .reset_n   (reset_n),
    .done      (mem_done),
    .kind      (kind_q),
    .fetch_cnt (fetch_cnt),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt)
  );
`endif

endmodule
